// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Purpose
//   Shares a single FIFO write port between N_REQ producers using round-robin
//   arbitration. The block keeps its own credit counter mirroring the FIFO
//   occupancy (pushes it issues minus pops it observes), so it never pushes
//   into a full FIFO. Data and the push strobe to the FIFO are registered,
//   which gives a one-cycle latency from grant to push.
//
// Parameters
//   N_REQ     number of requesters (2..8)
//   WIDTH     data width per requester and to the FIFO
//   DEPTH     FIFO capacity in entries; must match the attached FIFO
//   MAX_BURST max consecutive grants to one locked requester (lock build only)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous, active-low reset
//   req        in   [N_REQ]       request per producer, held until granted
//   data       in   [N_REQ*WIDTH] producer i data on bits [i*WIDTH +: WIDTH]
//   lock       in   [N_REQ]       burst-lock request per producer
//   grant      out  [N_REQ]       one-hot, combinational
//   fifo_in    out  [WIDTH]       registered data to the FIFO
//   fifo_push  out                registered push strobe to the FIFO
//   fifo_pop   in                 copy of the pop strobe driven into the FIFO
//   count      out  [CNT_W]       credit-counter occupancy, registered
//   full       out                count == DEPTH
//   empty      out                count == 0
//
// Handshake
//   A producer raises req[i] with data valid on its slice and holds both until
//   it sees grant[i]. req[i] & grant[i] in a cycle means the data slice was
//   accepted at the next rising edge; the producer may then change data or
//   drop req. Dropping req before a grant simply withdraws the request.
//
// Configuration
//   ARB_LOCK_EN  when defined, a winner w with lock[w]=1 keeps priority while
//                req[w]&lock[w] stays high, for up to MAX_BURST consecutive
//                grants, after which rotation resumes from w. When undefined
//                the lock input is ignored and arbitration is pure
//                round-robin.
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  input  logic [N_REQ-1:0]       lock,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       fifo_in,
  output logic                   fifo_push,
  input  logic                   fifo_pop,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Registered state
  logic [PTR_W-1:0] r_rr_ptr;   // last winner; search starts one above it
  logic [CNT_W-1:0] r_count;
  logic             r_push;
  logic [WIDTH-1:0] r_in;

  // Combinational
  logic             w_pop_eff;
  logic             w_space;
  logic             w_allow;
  logic [PTR_W-1:0] w_rr_idx;
  logic [PTR_W-1:0] w_win_idx;

  // A pop while the counter is already zero is ignored so the credit count
  // cannot wrap below zero.
  assign w_pop_eff = fifo_pop && (r_count != '0);

  // A pop in the same cycle frees one slot, so a grant is allowed at full
  // when there is a real pop to make room for it.
  assign w_space = (r_count < CNT_W'(DEPTH)) || w_pop_eff;

  // rst_n gates the grant so no producer sees an acceptance while the block
  // is held in reset.
  assign w_allow = rst_n && (|req) && w_space;

  // Round-robin search: walk offsets N_REQ down to 1 so the smallest offset
  // with req set (the first one after r_rr_ptr, wrapping) is assigned last
  // and wins. Offset N_REQ is r_rr_ptr itself, so a lone requester can be
  // granted back to back.
  always_comb begin
    w_rr_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_rr_idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [BURST_W-1:0] r_burst_cnt;  // consecutive locked grants to r_rr_ptr
  logic               w_owner_lock;
  logic               w_hold;

  // The last winner is r_rr_ptr; it keeps priority while it still asks with
  // lock and has burst budget left.
  assign w_owner_lock = req[r_rr_ptr] && lock[r_rr_ptr];
  assign w_hold       = (r_burst_cnt != '0) &&
                        (r_burst_cnt < BURST_W'(MAX_BURST)) &&
                        w_owner_lock;
  assign w_win_idx    = w_hold ? r_rr_ptr : w_rr_idx;

  // A locked grant that continues the current burst increments the count;
  // a locked grant won through rotation starts a new burst at 1. Any
  // unlocked grant, or the owner dropping req/lock, ends the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (w_allow) begin
      if (lock[w_win_idx]) begin
        r_burst_cnt <= w_hold ? (r_burst_cnt + BURST_W'(1)) : BURST_W'(1);
      end else begin
        r_burst_cnt <= '0;
      end
    end else if (!w_owner_lock) begin
      r_burst_cnt <= '0;
    end
  end
`else
  logic w_unused_lock;

  // Lock input and burst limit have no function in the round-robin build.
  assign w_unused_lock = (^lock) ^ (MAX_BURST > 0);
  assign w_win_idx     = w_rr_idx;
`endif

  // One-hot grant; w_allow implies |req, and the selected index has req set.
  always_comb begin
    grant = '0;
    if (w_allow) begin
      grant[w_win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= PTR_W'(N_REQ - 1);
      r_count  <= '0;
      r_push   <= 1'b0;
      r_in     <= '0;
    end else begin
      r_push <= w_allow;
      if (w_allow) begin
        r_in     <= data[w_win_idx*WIDTH +: WIDTH];
        r_rr_ptr <= w_win_idx;
      end
      // Push and pop in the same cycle cancel out.
      r_count <= r_count + CNT_W'(w_allow) - CNT_W'(w_pop_eff);
    end
  end

  assign fifo_push = r_push;
  assign fifo_in   = r_in;
  assign count     = r_count;
  // Decoded from the registered counter only: no path from req to full/empty.
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int MAXB  = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   lock;
  logic [N-1:0]   grant;
  logic [W-1:0]   fifo_in;
  logic           fifo_push;
  logic           fifo_pop;
  logic [2:0]     count;
  logic           full;
  logic           empty;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .lock(lock),
    .grant(grant), .fifo_in(fifo_in), .fifo_push(fifo_push),
    .fifo_pop(fifo_pop), .count(count), .full(full), .empty(empty)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];   // data expected on upcoming push cycles
  int           m_count;    // entries held in the FIFO
  int           m_last;     // most recent winner
  int           m_burst;    // consecutive locked grants to m_last
  logic         m_push;
  logic [W-1:0] m_in;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_last  = N - 1;
    m_burst = 0;
    m_push  = 1'b0;
    m_in    = '0;
    exp_q.delete();
  endtask

  // Who should win this cycle (-1 for nobody), from the arbitration rules.
  task automatic model_winner(output int w, output bit hold);
    bit room;
    w    = -1;
    hold = LOCK && (m_burst > 0) && (m_burst < MAXB) && req[m_last] && lock[m_last];
    room = (m_count < DEPTH) || (fifo_pop && m_count > 0);
    if (req != 0 && room) begin
      if (hold) w = m_last;
      else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        end
      end
    end
  endtask

  // One clock cycle: inputs are already driven (just after a rising edge).
  task automatic run_cycle(output logic [N-1:0] g_seen);
    int   w;
    bit   hold;
    logic [N-1:0] eg;
    model_winner(w, hold);
    eg = (w >= 0) ? N'(1 << w) : '0;
    #3;
    chk("grant", grant, eg);
    g_seen = grant;
    @(posedge clk);
    if (w >= 0) begin
      m_push = 1'b1;
      m_in   = data[w*W +: W];
      exp_q.push_back(m_in);
      if (LOCK) m_burst = lock[w] ? (hold ? m_burst + 1 : 1) : 0;
      m_last = w;
    end else begin
      m_push = 1'b0;
      if (!(req[m_last] && lock[m_last])) m_burst = 0;
    end
    m_count = m_count + ((w >= 0) ? 1 : 0) - ((fifo_pop && m_count > 0) ? 1 : 0);
    #1;
    chk("fifo_push", fifo_push, m_push);
    chk("fifo_in", fifo_in, m_in);
    chk("count", count, m_count);
    chk("full", full, m_count == DEPTH);
    chk("empty", empty, m_count == 0);
    if (fifo_push) begin
      if (exp_q.size() == 0) chk("sb_unexpected_push", 1, 0);
      else chk("sb_data", fifo_in, exp_q.pop_front());
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    req      = '1;     // grant must stay low while reset is asserted
    lock     = '0;
    fifo_pop = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    repeat (2) @(posedge clk);
    chk("rst_push", fifo_push, 0);
    chk("rst_in", fifo_in, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    model_reset();
    #1;
    req   = '0;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         pop;
    logic [N-1:0] g;
    logic         push;
    logic [W-1:0] din;
    int           cnt;
  } vec_t;

  vec_t vecs[16];
  logic [N-1:0] g;

  initial begin
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 8'h11, 1};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'h22, 2};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'h33, 3};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'h44, 4};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 8'h44, 4};  // full
    vecs[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 4};  // push+pop at full
    vecs[6]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 8'h11, 4};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 3};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 1};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 0};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 0};  // pop on empty ignored
    vecs[12] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 8'h33, 1};
    vecs[13] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 8'h11, 1};
    vecs[14] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 8'h33, 1};
    vecs[15] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 8'h11, 1};

    data = {8'h44, 8'h33, 8'h22, 8'h11};
    apply_reset();

    // Idle after reset release
    for (int i = 0; i < 5; i++) begin
      req = '0; fifo_pop = 1'b0;
      run_cycle(g);
      chk("idle_grant", g, 0);
    end

    // Table-driven sequence: fill, full, push+pop at full, drain, alternation
    foreach (vecs[i]) begin
      req      = vecs[i].req;
      fifo_pop = vecs[i].pop;
      run_cycle(g);
      chk($sformatf("vec%0d_grant", i), g, vecs[i].g);
      chk($sformatf("vec%0d_push", i), fifo_push, vecs[i].push);
      chk($sformatf("vec%0d_in", i), fifo_in, vecs[i].din);
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
    end

    // Reset in the middle of a push: count=2 with a push registered
    req = 4'b0001; fifo_pop = 1'b0;
    run_cycle(g);
    chk("mid_push_before", fifo_push, 1);
    chk("mid_count_before", count, 2);
    req   = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_push", fifo_push, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_grant", grant, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle(g);
    chk("rr_restart_grant", g, 4'b0001);

`ifdef ARB_LOCK_EN
    // Locked burst: requester 0 keeps priority for MAX_BURST grants
    apply_reset();
    req = 4'b0011; lock = 4'b0001; fifo_pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_cycle(g);
      chk($sformatf("lock_seq%0d", i), g, (i < MAXB) ? 4'b0001 : 4'b0010);
    end
    lock = '0;
`endif

    // Randomised traffic against the reference model
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req      = N'($urandom_range(0, 15));
      lock     = N'($urandom_range(0, 15));
      fifo_pop = ($urandom_range(0, 1) == 1);
      data     = $urandom;
      run_cycle(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
